axi_lite_arb_master: RTL

- Parametrised successor to the core's single-master memory interface unit.
- Arbitrates NCH independent request channels (fetch, mem, PTW, DMA, ...) onto one AXI4-Lite master port.
- Channels are granted round-robin or by fixed priority; one AXI transaction is in flight at a time.
- Write address and write data handshakes complete independently; AXI error responses are reported back to the requester.

---
 rtl/axi_lite_arb_master.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arb_master.sv
// Arbitrates NCH request channels (round-robin or fixed priority) onto one AXI4-Lite master, one transaction in flight.
// Latency: accept->resp_valid 3 cycles with a zero-wait slave; non-granted requests stay pending, VALIDs held until READY.
module axi_lite_arb_master #(
    parameter int          NCH      = 2,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          ARB_MODE = 1,
    parameter logic [2:0]  PROT     = 3'b000,
    localparam int         STRB_W   = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH-1:0]           req_write,
    input  logic [NCH*ADDR_W-1:0]    req_addr,
    input  logic [NCH*DATA_W-1:0]    req_wdata,
    input  logic [NCH*STRB_W-1:0]    req_wstrb,
    output logic [NCH-1:0]           resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic [ADDR_W-1:0]        axi_araddr,
    output logic                     axi_arvalid,
    output logic [2:0]               axi_arprot,
    input  logic                     axi_arready,
    input  logic [DATA_W-1:0]        axi_rdata,
    input  logic [1:0]               axi_rresp,
    input  logic                     axi_rvalid,
    output logic                     axi_rready,
    output logic [ADDR_W-1:0]        axi_awaddr,
    output logic                     axi_awvalid,
    output logic [2:0]               axi_awprot,
    input  logic                     axi_awready,
    output logic [DATA_W-1:0]        axi_wdata,
    output logic [STRB_W-1:0]        axi_wstrb,
    output logic                     axi_wvalid,
    input  logic                     axi_wready,
    input  logic [1:0]               axi_bresp,
    input  logic                     axi_bvalid,
    output logic                     axi_bready
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [NCH-1:0]      resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;

    logic                any_req;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    cand;
    int                  start_idx;
    logic                aw_now;
    logic                w_now;
    logic                unused_resp_lsb;

    assign unused_resp_lsb = ^{axi_rresp[0], axi_bresp[0]};

    // Search upward from start_idx with wrap; first valid channel wins.
    always_comb begin
        any_req   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        start_idx = (ARB_MODE != 0) ? int'(ptr_q) : 0;
        for (int i = 0; i < NCH; i++) begin
            cand = IDX_W'((start_idx + i) % NCH);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && any_req) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        aw_now       = aw_done_q | (awvalid_q & axi_awready);
        w_now        = w_done_q  | (wvalid_q  & axi_wready);

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d   = gnt_idx;
                    addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[gnt_idx*DATA_W +: DATA_W];
                    wstrb_d = req_wstrb[gnt_idx*STRB_W +: STRB_W];
                    if (int'(gnt_idx) == NCH - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                    if (req_write[gnt_idx]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (axi_rvalid) begin
                    rready_d            = 1'b0;
                    resp_data_d         = axi_rdata;
                    resp_err_d          = axi_rresp[1];
                    resp_valid_d[gnt_q] = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            S_WR: begin
                // AW and W complete independently; done flags remember the earlier one.
                if (awvalid_q && axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_now && w_now) begin
                    bready_d = 1'b1;
                    state_d  = S_B;
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    bready_d            = 1'b0;
                    resp_err_d          = axi_bresp[1];
                    resp_data_d         = '0;
                    resp_valid_d[gnt_q] = 1'b1;
                    state_d             = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign axi_araddr  = addr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arprot  = PROT;
    assign axi_rready  = rready_q;
    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awprot  = PROT;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;

endmodule
